dp_sink_aux_responder: RTL

Sink-side native AUX responder, the far end of the transaction-layer AUX initiator. It accepts decoded native AUX request transactions (command, address, length, write bytes) and answers with ACK/NACK/DEFER and read data. Read data comes from a small DPCD register map: capability, link-configuration and status windows. The link-configuration fields written by the source are exported to the sink PHY model. It is used as the sink model in the DP verification environment.

---
 rtl/dp_sink_aux_responder.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/dp_sink_aux_responder.sv
// Sink-side native AUX responder: decodes requests, answers ACK/NACK/DEFER, serves a
// three-window DPCD map (capability, link configuration, status) and exports link config.
module dp_sink_aux_responder #(
  parameter logic [7:0] DPCD_REV                 = 8'h12,
  parameter logic [7:0] MAX_LINK_RATE            = 8'h14,
  parameter logic [7:0] MAX_LANE_COUNT           = 8'h04,
  parameter logic [7:0] TRAINING_AUX_RD_INTERVAL = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        REQ_Start,
  input  logic [3:0]  REQ_CMD,
  input  logic [19:0] REQ_Address,
  input  logic [7:0]  REQ_LEN,
  input  logic [7:0]  REQ_Data,
  input  logic        REQ_Data_VLD,
  input  logic        Sink_Busy,
  input  logic [15:0] LANE_STATUS,
  input  logic [7:0]  ALIGN_STATUS,
  input  logic        RPL_Ready,
  output logic [1:0]  RPL_ACK,
  output logic        RPL_ACK_VLD,
  output logic [7:0]  RPL_Data,
  output logic        RPL_Data_VLD,
  output logic [7:0]  LINK_BW_SET,
  output logic [4:0]  LANE_COUNT_SET,
  output logic [1:0]  TPS_SET
);

  typedef enum logic [1:0] {IDLE, WR_COLLECT, SEND_ACK, RD_DATA} state_t;

  localparam logic [1:0] CODE_ACK   = 2'b00;
  localparam logic [1:0] CODE_NACK  = 2'b01;
  localparam logic [1:0] CODE_DEFER = 2'b10;

  localparam logic [1:0] WIN_CAP  = 2'd0;
  localparam logic [1:0] WIN_CFG  = 2'd1;
  localparam logic [1:0] WIN_STS  = 2'd2;
  localparam logic [1:0] WIN_NONE = 2'd3;

  state_t      state_q, state_d;
  logic [1:0]  win_q, win_d;
  logic [3:0]  off_q, off_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  idx_q, idx_d;
  logic [1:0]  code_q, code_d;
  logic        is_rd_q, is_rd_d;
  logic [1:0]  ack_q, ack_d;
  logic        ack_vld_q, ack_vld_d;
  logic [7:0]  data_q, data_d;
  logic        data_vld_q, data_vld_d;
  logic [7:0]  cfg_q [16];
  logic [7:0]  cfg_d [16];

  logic [1:0]  req_win;
  logic [8:0]  req_span;
  logic        req_ok;
  logic [1:0]  req_code;
  logic [3:0]  rd_off;
  logic [3:0]  wr_off;
  logic [7:0]  rd_byte;

  always_comb begin
    case (REQ_Address[19:4])
      16'h0000: req_win = WIN_CAP;
      16'h0010: req_win = WIN_CFG;
      16'h0020: req_win = WIN_STS;
      default:  req_win = WIN_NONE;
    endcase
    // a 9-bit sum so that offset+length past the window end cannot wrap back into it
    req_span = 9'(REQ_Address[3:0]) + 9'(REQ_LEN);
    req_ok   = ((REQ_CMD == 4'b1000) || (REQ_CMD == 4'b1001)) &&
               (REQ_LEN <= 8'd15) && (req_win != WIN_NONE) && (req_span <= 9'd15);
    if (Sink_Busy) begin
      req_code = CODE_DEFER;
    end else if (req_ok) begin
      req_code = CODE_ACK;
    end else begin
      req_code = CODE_NACK;
    end
  end

  // First byte comes out on the ACK handshake, later ones one past the accepted count
  always_comb begin
    rd_off  = (state_q == SEND_ACK) ? off_q : (off_q + idx_q[3:0] + 4'd1);
    wr_off  = off_q + idx_q[3:0];
    rd_byte = 8'h00;
    case (win_q)
      WIN_CAP: begin
        case (rd_off)
          4'h0:    rd_byte = DPCD_REV;
          4'h1:    rd_byte = MAX_LINK_RATE;
          4'h2:    rd_byte = {3'b000, MAX_LANE_COUNT[4:0]};
          4'hE:    rd_byte = TRAINING_AUX_RD_INTERVAL;
          default: rd_byte = 8'h00;
        endcase
      end
      WIN_CFG: rd_byte = cfg_q[rd_off];
      WIN_STS: begin
        case (rd_off)
          4'h2:    rd_byte = LANE_STATUS[7:0];
          4'h3:    rd_byte = LANE_STATUS[15:8];
          4'h4:    rd_byte = ALIGN_STATUS;
          default: rd_byte = 8'h00;
        endcase
      end
      default: rd_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    off_d      = off_q;
    len_d      = len_q;
    idx_d      = idx_q;
    code_d     = code_q;
    is_rd_d    = is_rd_q;
    ack_d      = ack_q;
    ack_vld_d  = ack_vld_q;
    data_d     = data_q;
    data_vld_d = data_vld_q;
    cfg_d      = cfg_q;

    case (state_q)
      IDLE: begin
        if (REQ_Start) begin
          win_d   = req_win;
          off_d   = REQ_Address[3:0];
          len_d   = REQ_LEN;
          code_d  = req_code;
          is_rd_d = (REQ_CMD == 4'b1001);
          idx_d   = 8'd0;
          // native writes always deliver their bytes, even when they will be refused
          if (REQ_CMD == 4'b1000) begin
            state_d = WR_COLLECT;
          end else begin
            state_d   = SEND_ACK;
            ack_d     = req_code;
            ack_vld_d = 1'b1;
          end
        end
      end

      WR_COLLECT: begin
        if (REQ_Data_VLD) begin
          if ((code_q == CODE_ACK) && (win_q == WIN_CFG)) begin
            cfg_d[wr_off] = REQ_Data;
          end
          if (idx_q == len_q) begin
            state_d   = SEND_ACK;
            ack_d     = code_q;
            ack_vld_d = 1'b1;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
      end

      SEND_ACK: begin
        if (RPL_Ready) begin
          ack_vld_d = 1'b0;
          ack_d     = CODE_ACK;
          if (is_rd_q && (code_q == CODE_ACK)) begin
            state_d    = RD_DATA;
            idx_d      = 8'd0;
            data_d     = rd_byte;
            data_vld_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end

      RD_DATA: begin
        if (RPL_Ready) begin
          if (idx_q == len_q) begin
            state_d    = IDLE;
            data_d     = 8'h00;
            data_vld_d = 1'b0;
          end else begin
            idx_d  = idx_q + 8'd1;
            data_d = rd_byte;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      win_q      <= WIN_CAP;
      off_q      <= 4'd0;
      len_q      <= 8'd0;
      idx_q      <= 8'd0;
      code_q     <= CODE_ACK;
      is_rd_q    <= 1'b0;
      ack_q      <= 2'b00;
      ack_vld_q  <= 1'b0;
      data_q     <= 8'h00;
      data_vld_q <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        cfg_q[i] <= 8'h00;
      end
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      off_q      <= off_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      code_q     <= code_d;
      is_rd_q    <= is_rd_d;
      ack_q      <= ack_d;
      ack_vld_q  <= ack_vld_d;
      data_q     <= data_d;
      data_vld_q <= data_vld_d;
      cfg_q      <= cfg_d;
    end
  end

  assign RPL_ACK        = ack_q;
  assign RPL_ACK_VLD    = ack_vld_q;
  assign RPL_Data       = data_q;
  assign RPL_Data_VLD   = data_vld_q;
  assign LINK_BW_SET    = cfg_q[0];
  assign LANE_COUNT_SET = cfg_q[1][4:0];
  assign TPS_SET        = cfg_q[2][1:0];

endmodule
